// File: rtl/dma_io_device_if.sv
// Local byte-stream port of the DMA I/O device.
//   wr_data/wr_valid/wr_ready : push side, feeds the FIFO for device-to-memory transfers
//   rd_data/rd_valid/rd_ready : pop side, drains the FIFO after memory-to-device transfers
// Modports: slave = device side, master = local client side.
interface dma_io_device_if;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;

  modport slave  (input  wr_data, wr_valid, rd_ready,
                  output wr_ready, rd_data, rd_valid);
  modport master (output wr_data, wr_valid, rd_ready,
                  input  wr_ready, rd_data, rd_valid);
endinterface

// File: rtl/dma_io_device.sv
// Slave I/O device for an 8237-style DMA controller, with a byte FIFO between the
// controller bus and a local valid/ready stream port.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_enable            : arms the channel, low forces IDLE
//   i_dir               : 0 = device-to-memory (IOR reads), 1 = memory-to-device (IOW writes)
//   lp                  : local push (dir=0) / pop (dir=1) stream port
//   o_dreq, i_dack      : DMA request / acknowledge, active-high
//   i_ior_n, i_iow_n    : controller I/O strobes, active-low
//   i_eop_n             : end of process, active-low
//   io_data             : controller data bus, driven only during a granted IOR
//   o_done              : one-cycle pulse on EOP termination
//   o_overrun           : sticky, a bus write arrived while the FIFO was full
//   o_count             : FIFO occupancy
module dma_io_device #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DEMAND = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_enable,
  input  logic                     i_dir,
  dma_io_device_if.slave           lp,
  output logic                     o_dreq,
  input  logic                     i_dack,
  input  logic                     i_ior_n,
  input  logic                     i_iow_n,
  input  logic                     i_eop_n,
  inout  wire  [7:0]               io_data,
  output logic                     o_done,
  output logic                     o_overrun,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_REQ, S_XFER, S_HOLDOFF, S_DONE
  } state_t;

  state_t        r_state;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_dir, r_dreq, r_done, r_overrun;
  logic          r_ior, r_ior_prev, r_iow, r_iow_prev, r_eop;
  logic [7:0]    r_wbyte;

  logic          w_full, w_empty, w_ior_rise, w_iow_rise, w_eop;
  logic          w_lp_push, w_lp_pop, w_bus_rd, w_bus_wr, w_push, w_pop;
  logic          w_xfer, w_cond, w_cond_nxt, w_drive;
  logic [7:0]    w_push_data;
  logic [CW-1:0] w_count_nxt;

  // Strobe edges come from the registered copies; DACK must be held for them to count
  assign w_ior_rise = ~r_ior_prev & r_ior & i_dack;
  assign w_iow_rise = ~r_iow_prev & r_iow & i_dack;
  assign w_eop      = ~r_eop & i_dack;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  assign w_lp_push = lp.wr_valid & lp.wr_ready;
  assign w_lp_pop  = lp.rd_valid & lp.rd_ready;
  assign w_bus_rd  = ~r_dir & w_ior_rise & (r_state == S_XFER) & ~w_empty;
  // Writes are still taken in HOLDOFF so a late write on a full FIFO flags overrun
  assign w_bus_wr  = r_dir & w_iow_rise & ((r_state == S_XFER) | (r_state == S_HOLDOFF));

  // A full FIFO still accepts a bus byte if the local side pops in the same cycle
  assign w_push      = w_lp_push | (w_bus_wr & (~w_full | w_lp_pop));
  assign w_pop       = w_lp_pop | w_bus_rd;
  assign w_push_data = r_dir ? r_wbyte : lp.wr_data;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  assign w_xfer      = w_bus_rd | w_bus_wr;

  // Transfer-ready condition, now and as it will be after this cycle's FIFO update
  assign w_cond     = r_dir ? ~w_full : ~w_empty;
  assign w_cond_nxt = r_dir ? (w_count_nxt != CW'(DEPTH)) : (w_count_nxt != '0);

  assign lp.wr_ready = ~w_full & ~r_dir;
  assign lp.rd_valid = ~w_empty & r_dir;
  assign lp.rd_data  = r_mem[r_rptr];

  // Reset gates the driver directly so the bus is released in the reset cycle itself
  assign w_drive = ~i_rst & (r_state == S_XFER) & ~r_dir & i_dack & ~i_ior_n & ~w_empty;
  assign io_data = w_drive ? r_mem[r_rptr] : 8'hzz;

  assign o_dreq    = r_dreq;
  assign o_done    = r_done;
  assign o_overrun = r_overrun;
  assign o_count   = r_count;

  // FIFO storage, not reset
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) r_mem[r_wptr] <= w_push_data;
  end

  // Pointers, strobe history, flags and channel state machine
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_dir      <= 1'b1;
      r_dreq     <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_ior      <= 1'b1;
      r_ior_prev <= 1'b1;
      r_iow      <= 1'b1;
      r_iow_prev <= 1'b1;
      r_eop      <= 1'b1;
      r_wbyte    <= '0;
    end else begin
      r_ior      <= i_ior_n;
      r_ior_prev <= r_ior;
      r_iow      <= i_iow_n;
      r_iow_prev <= r_iow;
      r_eop      <= i_eop_n;
      // Hold the last byte seen while IOW is low; it is pushed on the IOW rise
      if (r_dir && i_dack && !i_iow_n) r_wbyte <= io_data;

      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_nxt;
      if (w_bus_wr && !w_push) r_overrun <= 1'b1;

      if (r_state == S_IDLE) r_dir <= i_dir;
      r_done <= 1'b0;

      if (!i_enable) begin
        r_state <= S_IDLE;
        r_dreq  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_ARMED;
          S_ARMED: begin
            if (w_cond) begin
              r_state <= S_REQ;
              r_dreq  <= 1'b1;
            end
          end
          S_REQ: begin
            if (w_eop) begin
              r_state <= S_DONE;
              r_dreq  <= 1'b0;
              r_done  <= 1'b1;
            end else if (i_dack) begin
              r_state <= S_XFER;
            end
          end
          S_XFER: begin
            if (w_eop) begin
              r_state <= S_DONE;
              r_dreq  <= 1'b0;
              r_done  <= 1'b1;
            end else if (w_xfer) begin
              // Single mode always backs off; demand mode only when the FIFO runs dry/full
              if ((DEMAND == 0) || !w_cond_nxt) begin
                r_state <= S_HOLDOFF;
                r_dreq  <= 1'b0;
              end
            end else if (!i_dack) begin
              r_state <= S_ARMED;
              r_dreq  <= 1'b0;
            end
          end
          S_HOLDOFF: begin
            if (w_eop) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (!i_dack) begin
              r_state <= S_ARMED;
            end
          end
          S_DONE:  r_state <= S_DONE;
          default: begin
            r_state <= S_IDLE;
            r_dreq  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/dma_io_device.md
DMA_IO_DEVICE -- requirements
Module: dma_io_device

Interface
REQ-001 Parameter DEPTH, default 8, FIFO depth in bytes (power of two, 2..16).
REQ-002 Parameter DEMAND, default 1; 1 = demand mode (DREQ held while transfer possible), 0 = single mode (one byte per DREQ).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  arms the channel; 0 forces IDLE.
REQ-006 dir  input  1  0 = device-to-memory (controller reads device with IOR), 1 = memory-to-device (controller writes device with IOW); sampled only in IDLE.
REQ-007 wr_data/wr_valid/wr_ready  input 8 / input 1 / output 1  local push port, dir=0 only; push on wr_valid&wr_ready.
REQ-008 rd_data/rd_valid/rd_ready  output 8 / output 1 / input 1  local pop port, dir=1 only; pop on rd_valid&rd_ready.
REQ-009 DREQ  output  1  DMA request to controller, active-high.
REQ-010 DACK  input  1  DMA acknowledge from controller, active-high.
REQ-011 IOR, IOW  input  1 each  controller I/O strobes, active-low.
REQ-012 EOP  input  1  end of process, active-low.
REQ-013 Data  inout  8  controller data bus.
REQ-014 done  output  1  one-cycle pulse on EOP termination.
REQ-015 overrun  output  1  sticky; byte written while FIFO full.
REQ-016 count  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-017 IOR/IOW/EOP registered once (prev copies kept); strobe "rise" = prev low, current high, with DACK=1.
REQ-018 States: IDLE, ARMED, REQ, XFER, HOLDOFF, DONE.
REQ-019 IDLE: DREQ=0; enable=1 -> ARMED (dir latched).
REQ-020 Transfer-ready condition: dir=0: count>0; dir=1: count<DEPTH.
REQ-021 ARMED: condition true -> REQ next cycle; DREQ=1 exactly in REQ and XFER.
REQ-022 REQ: DACK=1 -> XFER.
REQ-023 dir=0, XFER: Data driven with FIFO head combinationally while DACK=1 and IOR=0, else high-Z; head popped on IOR rise.
REQ-024 dir=1, XFER: Data sampled on IOW low cycle, pushed on IOW rise; full FIFO -> byte dropped, overrun=1.
REQ-025 Device never drives Data when dir=1 or DACK=0.
REQ-026 Demand mode: after each transfer, condition false -> DREQ=0 next cycle, ARMED once DACK=0; else stay XFER.
REQ-027 Single mode: after each transfer -> HOLDOFF (DREQ=0); DACK=0 -> ARMED.
REQ-028 DACK falling in XFER with no strobe -> ARMED (controller preempted); FIFO unchanged.
REQ-029 EOP sampled low with DACK=1 in REQ/XFER/HOLDOFF -> DONE; a strobe rise in the same cycle still completes its byte.
REQ-030 DONE: DREQ=0, done pulses once on entry; enable=0 -> IDLE.
REQ-031 enable=0 in any state -> IDLE next cycle, DREQ=0; FIFO retained.
REQ-032 FIFO: circular pointers wrap mod DEPTH; simultaneous local and bus access same cycle both honoured, count unchanged.
REQ-033 wr_ready = (count<DEPTH) & dir=0; rd_valid = (count>0) & dir=1; rd_data = head.

Reset
REQ-034 Reset: state IDLE, pointers and count 0, DREQ=0, done=0, overrun=0, Data high-Z, wr_ready=0, rd_valid=0, prev strobes =1.
REQ-035 Reset mid-transfer discards FIFO contents and releases Data same cycle as reset takes effect.

Verification
REQ-036 dir=0, DEMAND=1: push 0x11,0x22,0x33; enable -> DREQ=1; DACK=1, three IOR pulses -> Data 0x11,0x22,0x33, DREQ=0 after third rise, count=0.
REQ-037 dir=0, DEMAND=0: push 0xA5,0x5A; DACK/IOR pulse -> Data 0xA5, HOLDOFF DREQ=0; DACK=0 -> DREQ=1 again for 0x5A.
REQ-038 dir=1: DEPTH=8, 8 IOW writes 0x01..0x08 -> count=8, DREQ=0; rd_ready=1 -> rd_data 0x01..0x08 in order, DREQ reasserts after first pop.
REQ-039 dir=1 full FIFO, forced IOW write 0xFF -> overrun=1, count stays 8, data not stored.
REQ-040 EOP low during second of four dir=0 transfers -> second byte completes, done pulse one cycle, DREQ=0, count=2 until enable toggled.
REQ-041 Reset asserted during XFER with IOR low -> Data high-Z, DREQ=0, count=0 next cycle.
